channel_state_fetch: RTL and testbench

//   Upstream sequencer for the per-channel parameter latch stage of the tracking engine.
//   On a start pulse it reads the STATE_WORDS words of one channel from the shared

---
 rtl/channel_state_fetch.sv | 61 ++++++
 tb/tb_channel_state_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_state_fetch.sv
// channel_state_fetch: reads one channel's state words from the shared RAM, word by word
// under req/gnt arbitration, and presents them to the parameter fill stage.
module channel_state_fetch #(
    parameter int CH_AW       = 5,
    parameter int STATE_WORDS = 16
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               fetch_start,
    input  logic [CH_AW-1:0]   fetch_channel,
    input  logic               fetch_abort,
    output logic               fetch_busy,
    output logic               fetch_done,
    output logic               ram_req,
    input  logic               ram_gnt,
    output logic [CH_AW+4:0]   ram_addr,
    output logic               ram_rd,
    input  logic [31:0]        ram_rdata,
    output logic               fill_enable,
    output logic               state_rd,
    output logic [4:0]         state_addr,
    output logic [31:0]        state_d4rd
);
    typedef enum logic [1:0] {IDLE, READ, LAST, DONE} state_t;
    localparam logic [4:0] LAST_WORD = 5'(STATE_WORDS - 1);
    state_t           state, state_nx;
    logic [CH_AW-1:0] chan_q;
    logic [4:0]       word_cnt;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            chan_q   <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && fetch_start && !fetch_abort) begin
                chan_q   <= fetch_channel;
                word_cnt <= '0;
            end else if (ram_rd) begin
                word_cnt <= word_cnt + 5'd1;
            end
        end
    end
    // abort gates the request combinationally so no read escapes in the abort cycle
    always_comb begin
        state_nx    = IDLE;
        ram_req     = (state == READ) && !fetch_abort;
        ram_rd      = ram_req && ram_gnt;
        state_rd    = ram_rd;
        ram_addr    = {chan_q, word_cnt};
        state_addr  = word_cnt;
        fill_enable = (state == READ) || (state == LAST);
        fetch_busy  = state != IDLE;
        fetch_done  = state == DONE;
        state_d4rd  = fill_enable ? ram_rdata : 32'd0;
        if (!fetch_abort)
            state_nx = state == IDLE ? (fetch_start ? READ : IDLE) :
                       state == READ ? (ram_rd && word_cnt == LAST_WORD ? LAST : READ) :
                       state == LAST ? DONE : IDLE;
    end
endmodule

// File: tb/tb_channel_state_fetch.sv
// tb_channel_state_fetch: scoreboard bench; expected RAM addresses are queued per fetch
// and popped as reads are observed, with read data and fill-stage latching checked a cycle later.
module tb_channel_state_fetch;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        fetch_start = 1'b0;
    logic [4:0]  fetch_channel = '0;
    logic        fetch_abort = 1'b0;
    logic        fetch_busy, fetch_done, ram_req, ram_gnt, ram_rd;
    logic [9:0]  ram_addr;
    logic [31:0] ram_rdata = '0;
    logic        fill_enable, state_rd;
    logic [4:0]  state_addr;
    logic [31:0] state_d4rd;

    int n_checks = 0;
    int n_fail = 0;
    logic [9:0]  exp_q[$];
    logic [63:0] stall_mask = '0;
    int          rcyc = 0;
    int          fe_cnt = 0;
    logic        d4rd_pending = 1'b0;
    logic [31:0] d4rd_exp = '0;
    logic        d4rd_word0 = 1'b0;
    logic [31:0] carrier_freq = '0;

    channel_state_fetch dut (
        .clk(clk), .rst_b(rst_b), .fetch_start(fetch_start), .fetch_channel(fetch_channel),
        .fetch_abort(fetch_abort), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
        .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_rdata(ram_rdata), .fill_enable(fill_enable), .state_rd(state_rd),
        .state_addr(state_addr), .state_d4rd(state_d4rd)
    );

    always #5 clk = ~clk;

    // grant is withheld on the READ cycles flagged in stall_mask
    assign ram_gnt = rcyc < 64 ? ~stall_mask[rcyc] : 1'b1;
    always @(posedge clk) rcyc <= ram_req ? rcyc + 1 : (fetch_busy ? rcyc : 0);
    always @(posedge clk) if (ram_rd) ram_rdata <= 32'hA5A50000 + {22'd0, ram_addr};

    always @(negedge clk) begin
        if (!rst_b) begin
            d4rd_pending = 1'b0;
        end else begin
            if (fill_enable) fe_cnt++;
            if (d4rd_pending) begin
                n_checks++;
                if (state_d4rd !== d4rd_exp) begin
                    n_fail++;
                    $display("FAIL state_d4rd got=%h exp=%h", state_d4rd, d4rd_exp);
                end
                if (d4rd_word0) carrier_freq = state_d4rd;
            end
            d4rd_pending = 1'b0;
            if (ram_rd) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read addr=%h exp=none", ram_addr);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if (ram_addr !== e || state_addr !== e[4:0] || state_rd !== 1'b1) begin
                        n_fail++;
                        $display("FAIL read_addr got=%h/%h/%b exp=%h/%h/1", ram_addr, state_addr,
                                 state_rd, e, e[4:0]);
                    end
                    d4rd_pending = 1'b1;
                    d4rd_exp = 32'hA5A50000 + {22'd0, e};
                    d4rd_word0 = e[4:0] == 5'd0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ch(input int ch);
        for (int w = 0; w < 16; w++) exp_q.push_back(10'(ch * 32 + w));
    endtask

    task automatic start_fetch(input int ch);
        fetch_start = 1'b1;
        fetch_channel = 5'(ch);
        tick();
        fetch_start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (fetch_done !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        #3;
        n_checks++;
        if ({fetch_busy, fetch_done, ram_req, ram_rd, fill_enable, state_rd} !== 6'b0 ||
            ram_addr !== 10'd0 || state_addr !== 5'd0 || state_d4rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b%b%b%b%b%b/%h/%h/%h exp=0", fetch_busy, fetch_done,
                     ram_req, ram_rd, fill_enable, state_rd, ram_addr, state_addr, state_d4rd);
        end
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_continuous();
        int k;
        push_ch(3);
        fe_cnt = 0;
        start_fetch(3);
        wait_done(k);
        k++;
        n_checks++;
        if (k !== 18) begin n_fail++; $display("FAIL cont_done_latency got=%0d exp=18", k); end
        n_checks++;
        if (fe_cnt !== 17) begin n_fail++; $display("FAIL cont_fill_enable got=%0d exp=17", fe_cnt); end
        tick();
        n_checks++;
        if (exp_q.size() !== 0 || fetch_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_complete got=%0d/%b exp=0/0", exp_q.size(), fetch_done);
        end
    endtask

    task automatic test_stall();
        int k;
        push_ch(7);
        stall_mask = 64'h0106;
        carrier_freq = '0;
        start_fetch(7);
        wait_done(k);
        k++;
        stall_mask = '0;
        n_checks++;
        if (k !== 21) begin n_fail++; $display("FAIL stall_done_latency got=%0d exp=21", k); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stall_complete got=%0d exp=0", exp_q.size()); end
        n_checks++;
        if (carrier_freq !== 32'hA5A500E0) begin
            n_fail++;
            $display("FAIL carrier_freq got=%h exp=a5a500e0", carrier_freq);
        end
        tick();
    endtask

    task automatic test_abort();
        int k;
        bit seen;
        for (int w = 0; w < 6; w++) exp_q.push_back(10'(4 * 32 + w));
        start_fetch(4);
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin tick(); k++; end
        fetch_abort = 1'b1;
        #1;
        n_checks++;
        if (ram_req !== 1'b0 || state_rd !== 1'b0 || ram_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_gating got=%b%b%b exp=000", ram_req, state_rd, ram_rd);
        end
        tick();
        fetch_abort = 1'b0;
        n_checks++;
        if (fetch_busy !== 1'b0 || fill_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle got=%b%b exp=00", fetch_busy, fill_enable);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (fetch_done === 1'b1) seen = 1;
            tick();
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort_no_done got=1 exp=0"); end
        push_ch(1);
        start_fetch(1);
        wait_done(k);
        k++;
        n_checks++;
        if (k !== 18 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL abort_refetch got=%0d/%0d exp=18/0", k, exp_q.size());
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int k;
        push_ch(2);
        start_fetch(2);
        repeat (3) tick();
        start_fetch(9);
        wait_done(k);
        k = k + 5;
        n_checks++;
        if (k !== 18) begin n_fail++; $display("FAIL busy_start_latency got=%0d exp=18", k); end
        start_fetch(9);
        n_checks++;
        if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored got=%b exp=0", fetch_busy); end
        tick();
        n_checks++;
        if (fetch_busy !== 1'b0 || ram_req !== 1'b0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL ignore_start_idle got=%b%b/%0d exp=00/0", fetch_busy, ram_req, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int k;
        push_ch(5);
        start_fetch(5);
        repeat (3) tick();
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({fetch_busy, fetch_done, ram_req, ram_rd, fill_enable, state_rd} !== 6'b0 ||
            ram_addr !== 10'd0 || state_addr !== 5'd0 || state_d4rd !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%b%b%b%b%b%b/%h/%h/%h exp=0", fetch_busy, fetch_done,
                     ram_req, ram_rd, fill_enable, state_rd, ram_addr, state_addr, state_d4rd);
        end
        tick();
        rst_b = 1'b1;
        exp_q.delete();
        tick();
        push_ch(0);
        start_fetch(0);
        wait_done(k);
        k++;
        n_checks++;
        if (k !== 18 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_refetch got=%0d/%0d exp=18/0", k, exp_q.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_stall();
        test_abort();
        test_ignore_start();
        test_reset_mid();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
